// File: rtl/mra_pkg.sv
// Shared types and constants for the MRA read-response unpacker.
package mra_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } resp_state_t;

    localparam int MRA_LINE_BYTES = 64;
    localparam int MRA_LINE_BITS  = MRA_LINE_BYTES * 8;
    localparam int MRA_WI_BITS    = MRA_LINE_BITS / 2;

    // Number of lines needed for n work items, two items per line.
    // One spare bit keeps an all-ones length from wrapping to zero.
    function automatic logic [64:0] ceil_half(input logic [63:0] n);
        return ({1'b0, n} + 65'd1) >> 1;
    endfunction

endpackage

// File: rtl/mra_line_fifo.sv
// Synchronous line FIFO with a registered head-of-queue output.
// rd_data_o always holds the oldest stored line once the queue is non-empty.
module mra_line_fifo #(
    parameter int  DEPTH = 20,
    parameter int  WIDTH = 512,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && (count_q != '0);
    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

    // Next pointers, occupancy and the line that will be at the head.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d  = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
        // The slot being written becomes the head only when nothing older remains.
        if (do_push || do_pop) begin
            rd_data_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers alone define what is valid.
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer, occupancy and head-register update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/mra_resp_unpacker.sv
// MRA read-response unpacker: queues response lines, splits each into two
// work items and pulses FIFO_rd_en once per retired line.
// Optional feature macro: MRA_RESP_CHK_EN adds the sticky resp_err flag.
module mra_resp_unpacker
    import mra_pkg::*;
#(
    parameter int WL_LEN_BITS    = 32,
    parameter int WI_QUEUE_DEPTH = 20,
    parameter int LINE_BITS      = MRA_LINE_BITS,
    parameter int WI_BITS        = MRA_WI_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WL_LEN_BITS-1:0] WL_len,
    input  logic                   start_dispatch,
    input  logic [LINE_BITS-1:0]   MRA_resp_data,
    input  logic                   MRA_resp_valid,
    output logic                   MRA_resp_ready,
    output logic [WI_BITS-1:0]     WI_data,
    output logic                   WI_valid,
    input  logic                   WI_ready,
    output logic                   WI_last,
    output logic                   FIFO_rd_en,
`ifdef MRA_RESP_CHK_EN
    output logic                   resp_err,
`endif
    output logic                   wl_done
);

    localparam int CNT_W = $clog2(WI_QUEUE_DEPTH + 1);

    resp_state_t            state_q;
    logic [WL_LEN_BITS-1:0] items_rem_q;
    logic [WL_LEN_BITS-1:0] lines_rem_q;
    logic                   half_sel_q;
    logic                   wl_done_q;

    logic [LINE_BITS-1:0]   line_data;
    logic                   fifo_full;
    logic [CNT_W-1:0]       fifo_count;
    logic                   push, wi_fire, retire, last_item;

    assign last_item      = (items_rem_q == WL_LEN_BITS'(1));
    assign MRA_resp_ready = (state_q == ACTIVE) && (lines_rem_q != '0) && !fifo_full;
    assign push           = MRA_resp_valid && MRA_resp_ready;
    assign WI_valid       = (state_q == ACTIVE) && (fifo_count != '0);
    assign wi_fire        = WI_valid && WI_ready;
    // Upper half done, or odd-length list ending on a lower half.
    assign retire         = wi_fire && (half_sel_q || last_item);
    assign FIFO_rd_en     = retire;
    assign WI_last        = WI_valid && last_item;
    assign WI_data        = half_sel_q ? line_data[LINE_BITS-1:WI_BITS] : line_data[WI_BITS-1:0];
    assign wl_done        = wl_done_q;

    mra_line_fifo #(
        .DEPTH (WI_QUEUE_DEPTH),
        .WIDTH (LINE_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (push),
        .wr_data_i (MRA_resp_data),
        .pop_i     (retire),
        .rd_data_o (line_data),
        .full_o    (fifo_full),
        .count_o   (fifo_count)
    );

    // Dispatch FSM with item/line counters, half select and the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            items_rem_q <= '0;
            lines_rem_q <= '0;
            half_sel_q  <= 1'b0;
            wl_done_q   <= 1'b0;
        end else begin
            wl_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_dispatch) begin
                        items_rem_q <= WL_len;
                        lines_rem_q <= WL_LEN_BITS'(ceil_half(64'(WL_len)));
                        half_sel_q  <= 1'b0;
                        if (WL_len != '0) begin
                            state_q <= ACTIVE;
                        end else begin
                            wl_done_q <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (push) begin
                        lines_rem_q <= lines_rem_q - WL_LEN_BITS'(1);
                    end
                    if (wi_fire) begin
                        items_rem_q <= items_rem_q - WL_LEN_BITS'(1);
                        half_sel_q  <= !retire;
                        if (last_item) begin
                            state_q   <= DONE;
                            wl_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MRA_RESP_CHK_EN
    logic resp_err_q;

    // Sticky flag for beats offered while no line is expected.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_err_q <= 1'b0;
        end else if (MRA_resp_valid && !((state_q == ACTIVE) && (lines_rem_q != '0))) begin
            resp_err_q <= 1'b1;
        end else if ((state_q == IDLE) && start_dispatch) begin
            resp_err_q <= 1'b0;
        end
    end

    assign resp_err = resp_err_q;
`endif

endmodule

// File: tb/tb_mra_resp_unpacker.sv
// Randomized scoreboard bench for mra_resp_unpacker.
// The reference model tracks the list as item/line counts and a queue of
// expected work items; a negedge monitor compares every cycle.
module tb_mra_resp_unpacker;

    localparam int DEPTH = 20;

    logic         clk;
    logic         rst;
    logic [31:0]  WL_len;
    logic         start_dispatch;
    logic [511:0] MRA_resp_data;
    logic         MRA_resp_valid;
    logic         MRA_resp_ready;
    logic [255:0] WI_data;
    logic         WI_valid;
    logic         WI_ready;
    logic         WI_last;
    logic         FIFO_rd_en;
    logic         wl_done;
`ifdef MRA_RESP_CHK_EN
    logic         resp_err;
`endif

    mra_resp_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .WL_len         (WL_len),
        .start_dispatch (start_dispatch),
        .MRA_resp_data  (MRA_resp_data),
        .MRA_resp_valid (MRA_resp_valid),
        .MRA_resp_ready (MRA_resp_ready),
        .WI_data        (WI_data),
        .WI_valid       (WI_valid),
        .WI_ready       (WI_ready),
        .WI_last        (WI_last),
        .FIFO_rd_en     (FIFO_rd_en),
`ifdef MRA_RESP_CHK_EN
        .resp_err       (resp_err),
`endif
        .wl_done        (wl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [255:0] data;
        bit           last;
        bit           retire;
    } item_t;

    item_t  exp_q[$];
    bit     m_active    = 0;
    longint m_len       = 0;
    longint m_items     = 0;
    longint m_lines     = 0;
    longint m_beat_idx  = 0;
    int     m_occ       = 0;
    bit     m_half      = 0;
    bit     m_done_next = 0;
    bit     m_after_rst = 0;
    bit     m_err       = 0;

    always @(negedge clk) begin : monitor
        bit    e_ready, e_valid, e_last, e_rd, fire, unexpected, idle_start;
        item_t it;
        e_ready = m_active && (m_lines > 0) && (m_occ < DEPTH);
        e_valid = m_active && (m_occ > 0);
        e_last  = e_valid && (exp_q.size() > 0) && exp_q[0].last;
        fire    = e_valid && WI_ready;
        e_rd    = fire && (exp_q.size() > 0) && exp_q[0].retire;

        check("ready", MRA_resp_ready, e_ready);
        check("wi_valid", WI_valid, e_valid);
        check("wi_last", WI_last, e_last);
        check("fifo_rd_en", FIFO_rd_en, e_rd);
        check("wl_done", wl_done, m_done_next);
        check("occupancy", dut.fifo_count, m_occ);
        if (fire && exp_q.size() > 0) check("wi_data", WI_data, exp_q[0].data);
        if (m_after_rst) check("wi_data_rst", WI_data, 256'd0);
`ifdef MRA_RESP_CHK_EN
        check("resp_err", resp_err, m_err);
`endif

        unexpected  = MRA_resp_valid && !(m_active && m_lines > 0);
        idle_start  = start_dispatch && !m_active;
        m_done_next = 0;
        m_after_rst = 0;
        if (rst) begin
            exp_q.delete();
            m_active    = 0;
            m_items     = 0;
            m_lines     = 0;
            m_occ       = 0;
            m_half      = 0;
            m_err       = 0;
            m_after_rst = 1;
        end else begin
            if (unexpected)      m_err = 1;
            else if (idle_start) m_err = 0;
            if (fire && exp_q.size() > 0) begin
                it = exp_q.pop_front();
                m_items--;
                if (it.retire) begin
                    m_occ--;
                    m_half = 0;
                end else begin
                    m_half = 1;
                end
                if (m_items == 0) begin
                    m_active    = 0;
                    m_done_next = 1;
                end
            end
            if (e_ready && MRA_resp_valid) begin
                it.data   = MRA_resp_data[255:0];
                it.last   = (2 * m_beat_idx == m_len - 1);
                it.retire = (2 * m_beat_idx + 1 >= m_len);
                exp_q.push_back(it);
                if (2 * m_beat_idx + 1 < m_len) begin
                    it.data   = MRA_resp_data[511:256];
                    it.last   = (2 * m_beat_idx + 1 == m_len - 1);
                    it.retire = 1;
                    exp_q.push_back(it);
                end
                m_beat_idx++;
                m_lines--;
                m_occ++;
            end
            if (idle_start) begin
                m_len      = longint'(WL_len);
                m_items    = m_len;
                m_lines    = (m_len + 1) / 2;
                m_beat_idx = 0;
                m_half     = 0;
                if (m_len == 0) m_done_next = 1;
                else            m_active    = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [511:0] rand_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step(input bit v, input bit r);
        MRA_resp_valid = v;
        MRA_resp_data  = rand_line();
        WI_ready       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic start_list(input logic [31:0] len);
        WL_len         = len;
        start_dispatch = 1'b1;
        MRA_resp_valid = 1'b0;
        WI_ready       = 1'b0;
        @(posedge clk);
        #1;
        start_dispatch = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input int vprob, input int rprob);
        int n = budget;
        while ((m_active || m_done_next) && n > 0) begin
            step($urandom_range(99) < vprob, $urandom_range(99) < rprob);
            n--;
        end
        if (m_active || m_done_next) begin
            n_checks++;
            $display("FAIL list_timeout: list still open after %0d cycles, required idle", budget);
        end
    endtask

    task automatic fill_to(input int occ, input int budget);
        int n = budget;
        while (m_occ < occ && n > 0) begin
            step(1'b1, 1'b0);
            n--;
        end
        check("fill_level", dut.fifo_count, occ);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        WL_len         = '0;
        start_dispatch = 1'b0;
        MRA_resp_valid = 1'b0;
        MRA_resp_data  = '0;
        WI_ready       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0);

        // Even length, back-to-back beats, consumer always ready.
        start_list(32'd4);
        wait_idle(60, 100, 100);
        step(1'b0, 1'b0);

        // Odd length: a third beat is refused and L1.hi never appears.
        start_list(32'd3);
        wait_idle(60, 100, 100);
        step(1'b0, 1'b0);

        // Fill to capacity with the consumer stalled, then drain.
        start_list(32'd50);
        repeat (25) step(1'b1, 1'b0);
        check("queue_full", dut.fifo_count, DEPTH);
        wait_idle(400, 100, 100);
        step(1'b0, 1'b0);

        // Push exactly on the retiring cycle so occupancy holds at five.
        start_list(32'd40);
        fill_to(5, 20);
        repeat (20) step(m_half, 1'b1);
        check("count_hold", dut.fifo_count, 5);
        wait_idle(400, 100, 100);
        step(1'b0, 1'b0);

        // Zero length: no beats taken, done pulse only.
        start_list(32'd0);
        wait_idle(10, 100, 100);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b0);

        // Maximum length must yield a non-zero line count.
        start_list(32'hFFFF_FFFF);
        step(1'b1, 1'b0);
        check("max_len_ready", MRA_resp_ready, 1'b1);
        repeat (3) step(1'b1, 1'b1);
        pulse_reset();

        // Reset in the middle of a list with seven lines queued.
        start_list(32'd20);
        fill_to(7, 20);
        pulse_reset();
        check("rst_empty", dut.fifo_count, 0);

`ifdef MRA_RESP_CHK_EN
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("err_set", resp_err, 1'b1);
        start_list(32'd2);
        step(1'b0, 1'b0);
        check("err_clear", resp_err, 1'b0);
        wait_idle(60, 100, 100);
        step(1'b0, 1'b0);
`endif

        // Random lists with random beat and consumer pacing.
        for (int l = 0; l < 10; l++) begin
            int vp, rp;
            vp = $urandom_range(90, 30);
            rp = $urandom_range(90, 30);
            start_list($urandom_range(45, 1));
            wait_idle(2000, vp, rp);
            step(1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
